// File: rtl/vga_sprite_pkg.sv
// Shared VGA sprite types and constants.
// Also defines the built-in test image used by sprite_rom.
package vga_sprite_pkg;

    localparam int COORD_W = 11;
    localparam logic [7:0] TRANSP_KEY_DEF = 8'hFF;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Every eighth texel (address mod 8 == 5) is transparent;
    // the rest carry an address hash with LSB 0, so they never equal 8'hFF.
    function automatic rgb332_t test_pixel(
        input logic [31:0] addr,
        input logic [7:0]  key
    );
        if ((addr & 32'd7) == 32'd5)
            return rgb332_t'(key);
        return rgb332_t'(8'(((addr >> 1) ^ (addr >> 8)) << 1));
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Frame image store with synchronous read, one cycle latency.
// INIT_FILE selects the image: "blank" is fully transparent, else test pattern.
module sprite_rom
    import vga_sprite_pkg::*;
#(
    parameter int          DEPTH     = 2704,
    parameter string       INIT_FILE = "",
    parameter logic [7:0]  KEY       = TRANSP_KEY_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    output rgb332_t                  o_data
);

    rgb332_t w_pix;
    rgb332_t r_data;

    generate
        if (INIT_FILE == "blank") begin : g_blank
            assign w_pix = rgb332_t'(KEY);
        end else begin : g_pattern
            assign w_pix = test_pixel(32'(i_addr), KEY);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_data <= '0;
        else
            r_data <= w_pix;
    end

    assign o_data = r_data;

endmodule

// File: rtl/sprite_anim_draw.sv
// Animated, optionally scaled and mirrored sprite drawer.
// Two-stage pipeline: hit/address register, then ROM data register.
module sprite_anim_draw
    import vga_sprite_pkg::*;
#(
    parameter int         OBJ_W      = 26,
    parameter int         OBJ_H      = 26,
    parameter int         NUM_FRAMES = 4,
    parameter int         FRAME_HOLD = 8,
    parameter int         SCALE_LOG2 = 0,
    parameter int         LOOP       = 1,
    parameter logic [7:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [COORD_W-1:0] oCoord_X,
    input  logic [COORD_W-1:0] oCoord_Y,
    input  logic [COORD_W-1:0] ObjectStartX,
    input  logic [COORD_W-1:0] ObjectStartY,
    input  logic               startOfFrame,
    input  logic               anim_enable,
    input  logic               anim_restart,
    input  logic               flip_x,
    output logic               drawing_request,
    output logic [7:0]         mVGA_RGB,
    output logic [3:0]         current_frame,
    output logic               anim_done
);

    localparam int DEPTH     = NUM_FRAMES * OBJ_W * OBJ_H;
    localparam int AW        = $clog2(DEPTH);
    localparam int FRAME_PIX = OBJ_W * OBJ_H;

    localparam logic [COORD_W:0] SPAN_X   = (COORD_W+1)'(OBJ_W << SCALE_LOG2);
    localparam logic [COORD_W:0] SPAN_Y   = (COORD_W+1)'(OBJ_H << SCALE_LOG2);
    localparam logic [3:0]       LAST_FR  = 4'(NUM_FRAMES - 1);
    localparam logic [7:0]       HOLD_MAX = 8'(FRAME_HOLD - 1);

    logic [COORD_W:0]   w_end_x;
    logic [COORD_W:0]   w_end_y;
    logic               w_hit;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [31:0]        w_col_raw;
    logic [31:0]        w_col;
    logic [31:0]        w_row;
    logic [AW-1:0]      w_addr;
    rgb332_t            w_rom_data;

    logic               r_hit1;
    logic               r_hit2;
    logic [AW-1:0]      r_addr1;
    logic [3:0]         r_frame;
    logic [7:0]         r_hold;
    logic               r_done;

    // End coordinates carry one extra bit so boxes near 2047 never wrap.
    assign w_end_x = {1'b0, ObjectStartX} + SPAN_X;
    assign w_end_y = {1'b0, ObjectStartY} + SPAN_Y;

    assign w_hit = (oCoord_X >= ObjectStartX)
                && ({1'b0, oCoord_X} < w_end_x)
                && (oCoord_Y >= ObjectStartY)
                && ({1'b0, oCoord_Y} < w_end_y);

    assign w_dx      = oCoord_X - ObjectStartX;
    assign w_dy      = oCoord_Y - ObjectStartY;
    assign w_col_raw = 32'(w_dx >> SCALE_LOG2);
    assign w_row     = 32'(w_dy >> SCALE_LOG2);
    assign w_col     = flip_x ? (32'(OBJ_W - 1) - w_col_raw) : w_col_raw;

    assign w_addr = AW'(32'(r_frame) * 32'(FRAME_PIX)
                      + w_row * 32'(OBJ_W)
                      + w_col);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hit1  <= 1'b0;
            r_addr1 <= '0;
            r_hit2  <= 1'b0;
        end else begin
            r_hit1  <= w_hit;
            r_addr1 <= w_addr;
            r_hit2  <= r_hit1;
        end
    end

    sprite_rom #(
        .DEPTH     (DEPTH),
        .INIT_FILE (""),
        .KEY       (TRANSP_KEY)
    ) u_rom (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_addr (r_addr1),
        .o_data (w_rom_data)
    );

    // Frame only moves on a startOfFrame edge, so a scan never tears.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else if (anim_restart) begin
            r_frame <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else if (startOfFrame && anim_enable) begin
            if (r_hold == HOLD_MAX) begin
                r_hold <= '0;
                if (r_frame != LAST_FR)
                    r_frame <= r_frame + 4'd1;
                else if (LOOP != 0)
                    r_frame <= '0;
                else
                    r_done <= 1'b1;
            end else begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign drawing_request = r_hit2 && (w_rom_data != rgb332_t'(TRANSP_KEY));
    assign mVGA_RGB        = drawing_request ? w_rom_data : 8'h00;
    assign current_frame   = r_frame;
    assign anim_done       = r_done;

endmodule

// File: tb/tb_sprite_anim_draw.sv
// Scoreboard bench for sprite_anim_draw: two instances (1x looping, 2x one-shot).
// Expected pixels come from a geometric sprite model and a pulse-count animation model.
module tb_sprite_anim_draw;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x, y, sx, sy;
    logic        sof, en, restart, flip;
    logic        dr_a, dr_b, done_a, done_b;
    logic [7:0]  rgb_a, rgb_b;
    logic [3:0]  fr_a, fr_b;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int n_en  = 0;

    typedef struct {
        int         due;
        int         dut;
        int         kind;
        string      tag;
        logic       dr;
        logic [7:0] rgb;
        logic [3:0] frame;
        logic       done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_anim_draw dut_a (
        .CLK(clk), .RESET(rst),
        .oCoord_X(x), .oCoord_Y(y),
        .ObjectStartX(sx), .ObjectStartY(sy),
        .startOfFrame(sof), .anim_enable(en),
        .anim_restart(restart), .flip_x(flip),
        .drawing_request(dr_a), .mVGA_RGB(rgb_a),
        .current_frame(fr_a), .anim_done(done_a)
    );

    sprite_anim_draw #(.SCALE_LOG2(1), .LOOP(0)) dut_b (
        .CLK(clk), .RESET(rst),
        .oCoord_X(x), .oCoord_Y(y),
        .ObjectStartX(sx), .ObjectStartY(sy),
        .startOfFrame(sof), .anim_enable(en),
        .anim_restart(restart), .flip_x(flip),
        .drawing_request(dr_b), .mVGA_RGB(rgb_b),
        .current_frame(fr_b), .anim_done(done_b)
    );

    // Test image: frames of 26x26 texels laid out frame-major, row-major.
    function automatic logic [7:0] img(input int f, input int r, input int c);
        int a;
        a = f * 676 + r * 26 + c;
        if (a % 8 == 5) return 8'hFF;
        return 8'((((a / 2) ^ (a / 256)) * 2) % 256);
    endfunction

    function automatic int frame_of(input int dut);
        int steps;
        steps = n_en / 8;
        if (dut == 0) return steps % 4;
        return (steps > 3) ? 3 : steps;
    endfunction

    function automatic exp_t mk_pix(input int dut, input int due, input string tag);
        exp_t e;
        int s, span, col, row, xi, yi, sxi, syi;
        logic [7:0] c;
        s = dut; span = 26 << s;
        xi = int'(x); yi = int'(y); sxi = int'(sx); syi = int'(sy);
        e.due = due; e.dut = dut; e.kind = 0; e.tag = tag;
        e.dr = 1'b0; e.rgb = 8'h00; e.frame = '0; e.done = 1'b0;
        if (xi >= sxi && xi < sxi + span && yi >= syi && yi < syi + span) begin
            col = (xi - sxi) >> s;
            row = (yi - syi) >> s;
            if (flip) col = 25 - col;
            c = img(frame_of(dut), row, col);
            if (c != 8'hFF) begin
                e.dr = 1'b1;
                e.rgb = c;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk_anim(input int dut, input int due, input string tag);
        exp_t e;
        e.due = due; e.dut = dut; e.kind = 1; e.tag = tag;
        e.dr = 1'b0; e.rgb = 8'h00;
        e.frame = 4'(frame_of(dut));
        e.done = (dut == 1) && (n_en >= 32);
        return e;
    endfunction

    function automatic exp_t mk_zero(input int dut, input int due, input string tag);
        exp_t e;
        e.due = due; e.dut = dut; e.kind = 0; e.tag = tag;
        e.dr = 1'b0; e.rgb = 8'h00; e.frame = '0; e.done = 1'b0;
        return e;
    endfunction

    task automatic check(input exp_t e);
        logic       adr, adone;
        logic [7:0] argb;
        logic [3:0] afr;
        adr   = e.dut ? dr_b   : dr_a;
        argb  = e.dut ? rgb_b  : rgb_a;
        afr   = e.dut ? fr_b   : fr_a;
        adone = e.dut ? done_b : done_a;
        tests++;
        if (e.kind == 0) begin
            if (adr !== e.dr || argb !== e.rgb) begin
                fails++;
                $display("FAIL %s dut%0d x=%0d y=%0d: got dr=%b rgb=%h, expected dr=%b rgb=%h",
                         e.tag, e.dut, x, y, adr, argb, e.dr, e.rgb);
            end
        end else begin
            if (afr !== e.frame || adone !== e.done) begin
                fails++;
                $display("FAIL %s dut%0d: got frame=%0d done=%b, expected frame=%0d done=%b",
                         e.tag, e.dut, afr, adone, e.frame, e.done);
            end
        end
    endtask

    // Monitor: compare each expectation in the cycle its output is due.
    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].due == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s dut%0d: expectation expired at cycle %0d", sb[i].tag, sb[i].dut, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic pix(input int xx, input int yy, input int sxx, input int syy,
                       input logic fl, input string tag);
        @(negedge clk);
        x = 11'(xx); y = 11'(yy); sx = 11'(sxx); sy = 11'(syy); flip = fl;
        sb.push_back(mk_pix(0, cyc + 2, tag));
        sb.push_back(mk_pix(1, cyc + 2, tag));
    endtask

    task automatic pulse(input logic e_, input logic rs, input string tag);
        @(negedge clk);
        sof = 1'b1; en = e_; restart = rs;
        if (rs) n_en = 0;
        else if (e_) n_en++;
        sb.push_back(mk_anim(0, cyc + 1, tag));
        sb.push_back(mk_anim(1, cyc + 1, tag));
        @(negedge clk);
        sof = 1'b0; restart = 1'b0;
    endtask

    task automatic rand_scan(input int n, input string tag);
        int bx, by;
        for (int i = 0; i < n; i++) begin
            bx = int'($urandom_range(0, 2047));
            by = int'($urandom_range(0, 2047));
            pix((bx + int'($urandom_range(0, 60)) - 3) % 2048,
                (by + int'($urandom_range(0, 60)) - 3) % 2048,
                bx, by, 1'($urandom_range(0, 1)), tag);
        end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; sx = 11'd100; sy = 11'd50;
        sof = 1'b0; en = 1'b1; restart = 1'b0; flip = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check(mk_zero(0, cyc, "reset_pix"));
        check(mk_zero(1, cyc, "reset_pix"));
        check(mk_anim(0, cyc, "reset_anim"));
        check(mk_anim(1, cyc, "reset_anim"));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 99; i <= 126; i++) pix(i, 60, 100, 50, 1'b0, "scan_row");
        for (int i = 0; i <= 53; i++) pix(i, 10, 0, 0, 1'b0, "scale_row");
        for (int i = 99; i <= 127; i++) pix(i, 55, 100, 50, 1'b1, "flip_row");
        for (int i = 2040; i <= 2047; i++) pix(i, 5, 2040, 0, 1'b0, "edge_hit");
        for (int i = 0; i <= 17; i++) pix(i, 5, 2040, 0, 1'b0, "edge_nowrap");

        for (int i = 0; i < 32; i++) pulse(1'b1, 1'b0, "anim_32");
        rand_scan(40, "rand_after32");
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, "anim_40");
        rand_scan(40, "rand_after40");
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, "hold_en");
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, "hold_frozen");
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, "hold_resume");
        for (int i = 99; i <= 126; i++) pix(i, 70, 100, 50, 1'b0, "scan_frame2");
        pulse(1'b1, 1'b1, "restart_sof");
        rand_scan(150, "rand_frame0");

        for (int i = 100; i <= 110; i++) pix(i, 60, 100, 50, 1'b0, "pre_reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        n_en = 0;
        #1;
        check(mk_zero(0, cyc, "async_reset"));
        check(mk_zero(1, cyc, "async_reset"));
        check(mk_anim(0, cyc, "async_reset_anim"));
        check(mk_anim(1, cyc, "async_reset_anim"));
        x = 11'd105; y = 11'd61;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        x = 11'd106; y = 11'd60;
        sb.push_back(mk_zero(0, cyc + 1, "post_reset_idle"));
        sb.push_back(mk_zero(1, cyc + 1, "post_reset_idle"));
        sb.push_back(mk_pix(0, cyc + 2, "post_reset_first"));
        sb.push_back(mk_pix(1, cyc + 2, "post_reset_first"));
        for (int i = 107; i <= 127; i++) pix(i, 60, 100, 50, 1'b0, "post_reset_scan");

        repeat (4) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_anim_draw.md
SPRITE_ANIM_DRAW -- requirements
Module: sprite_anim_draw

Interface
REQ-001 Parameter OBJ_W, default 26, sprite width in source pixels.
REQ-002 Parameter OBJ_H, default 26, sprite height in source pixels.
REQ-003 Parameter NUM_FRAMES, default 4, animation frames stored (1..16).
REQ-004 Parameter FRAME_HOLD, default 8, display frames each animation frame is held (1..255).
REQ-005 Parameter SCALE_LOG2, default 0, integer upscale factor 2**SCALE_LOG2 (0..2).
REQ-006 Parameter LOOP, default 1, 1 = wrap to frame 0 after the last frame, 0 = stop on the last frame.
REQ-007 Parameter TRANSP_KEY, default 8'hFF, colour code treated as transparent.
REQ-008 CLK  in  1  system/pixel clock; one clock domain only.
REQ-009 RESET  in  1  asynchronous, active-high reset.
REQ-010 oCoord_X  in  11  current scan X.
REQ-011 oCoord_Y  in  11  current scan Y.
REQ-012 ObjectStartX  in  11  sprite top-left X.
REQ-013 ObjectStartY  in  11  sprite top-left Y.
REQ-014 startOfFrame  in  1  one-cycle pulse per display frame.
REQ-015 anim_enable  in  1  permits frame advance.
REQ-016 anim_restart  in  1  synchronous return to frame 0.
REQ-017 flip_x  in  1  horizontal mirror.
REQ-018 drawing_request  out  1  opaque sprite pixel present.
REQ-019 mVGA_RGB  out  8  RGB332 pixel colour.
REQ-020 current_frame  out  4  displayed frame index.
REQ-021 anim_done  out  1  high while stopped on the last frame (LOOP=0 only).

Function
REQ-022 Rectangle hit when StartX <= X < StartX + (OBJ_W << SCALE_LOG2), with the same rule in Y; end coordinates are computed at 12 bits so no wrap-around occurs near 2047.
REQ-023 Source column = (X - StartX) >> SCALE_LOG2; source row = (Y - StartY) >> SCALE_LOG2; when flip_x=1, column = OBJ_W-1-column.
REQ-024 ROM address = current_frame*OBJ_W*OBJ_H + row*OBJ_W + column; width = clog2(NUM_FRAMES*OBJ_W*OBJ_H).
REQ-025 Pipeline stage 1 registers the hit flag and address; stage 2 registers the ROM data; total latency from coordinate to output is exactly 2 CLK cycles.
REQ-026 drawing_request = delayed hit AND (ROM data != TRANSP_KEY); mVGA_RGB = ROM data when drawing_request=1, else 8'h00.
REQ-027 Hold counter increments on each startOfFrame while anim_enable=1; at FRAME_HOLD-1 it clears and the frame advances by one.
REQ-028 Advance from frame NUM_FRAMES-1 goes to 0 when LOOP=1; when LOOP=0 the frame stays and anim_done is set.
REQ-029 current_frame changes only in the cycle after a startOfFrame pulse, so no frame switch occurs mid-scan.
REQ-030 anim_restart clears the frame, the hold counter and anim_done; it takes priority over a simultaneous startOfFrame advance.
REQ-031 anim_enable=0 freezes the hold counter and frame; hold count is kept, not cleared.
REQ-032 NUM_FRAMES=1 or FRAME_HOLD=1 is legal: frame is constant, or advances on every startOfFrame, respectively.

Reset
REQ-033 RESET asynchronously clears drawing_request, mVGA_RGB, current_frame, anim_done, hold counter and all pipeline registers to 0.
REQ-034 Reset asserted mid-scan forces drawing_request=0 immediately; the first valid output appears 2 cycles after release.

Structure
REQ-035 Package vga_sprite_pkg holds the RGB332 typedef, the TRANSP_KEY default and the coordinate width constant (11).
REQ-036 Sub-module sprite_rom (parameters DEPTH, INIT_FILE; synchronous read, 1-cycle latency) holds the frame images; the control, counters and address logic stay in sprite_anim_draw.

Verification
REQ-037 Start=(100,50), scan X=99..126 with Y=60 -> drawing_request high only for X=100..125 (opaque pixels), each 2 cycles after the coordinate.
REQ-038 SCALE_LOG2=1, Start=(0,0) -> the box spans 52x52; X=0,1 map to the same source column; X=52 -> no hit.
REQ-039 flip_x=1, X=StartX -> colour equals source column 25 of the current frame.
REQ-040 FRAME_HOLD=8, NUM_FRAMES=4, LOOP=1, 32 startOfFrame pulses -> current_frame steps 0,1,2,3,0 at pulses 8,16,24,32.
REQ-041 LOOP=0, 40 pulses -> current_frame stops at 3 and anim_done=1; anim_restart with a simultaneous startOfFrame -> frame 0, anim_done=0.
REQ-042 Start=(2040,0), X=2040..2047 -> hit for all 8 columns, with no false hit at X=0..17.
